// File: rtl/pacman_mover.sv
`default_nettype none
// ============================================================================
// Module      : pacman_mover
// Description : Owns Pac-Man's pixel position. It steps one pixel per
//               STEP_PERIOD frame ticks in the direction requested by the
//               direction controller. On every tile-aligned position it
//               reads the four neighbour tiles (U, R, D, L) from the wall map
//               and publishes them as adjacent_walls / walls_valid.
// Ports       : Clk, Reset (sync, active-high), Restart (same as Reset)
//               frame_tick     - 1-cycle pulse per video frame
//               direction[2:0] - 000 stop, 100 up, 101 right, 110 down,
//                                111 left; 001-011 act as stop
//               map_rd/map_addr/map_data - wall-map read port, data valid
//                                MAP_LAT cycles after map_rd
//               pacman_x/pacman_y - position in pixels (16 px tiles)
//               adjacent_walls[3:0] - [0] up [1] right [2] down [3] left
//               walls_valid    - adjacent_walls belongs to current tile
// Config      : define TUNNEL_WRAP_EN to wrap columns -1/MAP_W and x.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_mover #(
  parameter int MAP_W       = 28,
  parameter int MAP_H       = 31,
  parameter int ADDR_W      = 10,
  parameter int MAP_LAT     = 1,
  parameter int STEP_PERIOD = 1,
  parameter int START_X     = 208,
  parameter int START_Y     = 368
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Restart,
  input  logic              frame_tick,
  input  logic [2:0]        direction,
  output logic              map_rd,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_data,
  output logic [9:0]        pacman_x,
  output logic [9:0]        pacman_y,
  output logic [3:0]        adjacent_walls,
  output logic              walls_valid
);

  localparam int         LAT_W = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
  localparam int         CNT_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [9:0] X_MAX = 10'(MAP_W * 16 - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [3:0]          shadow_q, shadow_d;
  logic                forced_q, forced_d;   // current slot has no real read
  logic                trig_q, trig_d;       // lookup requested
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic [3:0]          adj_q, adj_d;
  logic                valid_q, valid_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;

  // Returns {readable, address} of the neighbour tile on the given side.
  // Off-map rows (and off-map columns without tunnel wrap) are not readable.
  function automatic logic [ADDR_W:0] neighbour(input logic [1:0] side,
                                                input logic [5:0] col_in,
                                                input logic [5:0] row_in);
    int row;
    int col;
    row = int'(row_in);
    col = int'(col_in);
    case (side)
      2'd0:    row = row - 1;
      2'd1:    col = col + 1;
      2'd2:    row = row + 1;
      default: col = col - 1;
    endcase
    if (row < 0 || row >= MAP_H) return {1'b0, {ADDR_W{1'b0}}};
`ifdef TUNNEL_WRAP_EN
    if (col < 0) col = MAP_W - 1;
    else if (col >= MAP_W) col = 0;
`else
    if (col < 0 || col >= MAP_W) return {1'b0, {ADDR_W{1'b0}}};
`endif
    return {1'b1, ADDR_W'(row * MAP_W + col)};
  endfunction

  logic [1:0]      nb_side;
  logic [ADDR_W:0] nb;
  logic            aligned;
  logic            step_go;

  // Side of the next slot to issue: UP when starting, else the one after idx_q.
  assign nb_side = (state_q == S_IDLE) ? 2'd0 : idx_q + 2'd1;
  assign nb      = neighbour(nb_side, x_q[9:4], y_q[9:4]);
  assign aligned = (x_q[3:0] == 4'd0) && (y_q[3:0] == 4'd0);
  // A pending lookup request blocks stepping so walls are never stale.
  assign step_go = pend_q && (state_q == S_IDLE) && valid_q && !trig_q;

  always_comb begin
    logic moved;
    state_d  = state_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    shadow_d = shadow_q;
    forced_d = forced_q;
    trig_d   = trig_q;
    x_d      = x_q;
    y_d      = y_q;
    adj_d    = adj_q;
    valid_d  = valid_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    moved    = 1'b0;

    // Lookup sequencer
    case (state_q)
      S_IDLE: begin
        if (trig_q) begin
          trig_d   = 1'b0;
          valid_d  = 1'b0;
          idx_d    = 2'd0;
          state_d  = S_ISSUE;
          rd_d     = nb[ADDR_W];
          addr_d   = nb[ADDR_W-1:0];
          forced_d = !nb[ADDR_W];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = '0;
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(MAP_LAT - 1)) begin
          shadow_d[idx_q] = forced_q | map_data;
          if (idx_q == 2'd3) begin
            state_d = S_COMMIT;
          end else begin
            state_d  = S_ISSUE;
            idx_d    = idx_q + 2'd1;
            rd_d     = nb[ADDR_W];
            addr_d   = nb[ADDR_W-1:0];
            forced_d = !nb[ADDR_W];
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: begin
        adj_d   = shadow_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Step execution; a wall blocks only when aligned, and motion is
    // allowed only along the axis on which the other coordinate is aligned.
    if (step_go) begin
      pend_d = 1'b0;
      case (direction)
        3'b100: if (x_q[3:0] == 4'd0 && !(aligned && adj_q[0])) begin
          y_d   = y_q - 10'd1;
          moved = 1'b1;
        end
        3'b101: if (y_q[3:0] == 4'd0 && !(aligned && adj_q[1])) begin
`ifdef TUNNEL_WRAP_EN
          x_d = (x_q == X_MAX) ? 10'd0 : x_q + 10'd1;
`else
          x_d = x_q + 10'd1;
`endif
          moved = 1'b1;
        end
        3'b110: if (x_q[3:0] == 4'd0 && !(aligned && adj_q[2])) begin
          y_d   = y_q + 10'd1;
          moved = 1'b1;
        end
        3'b111: if (y_q[3:0] == 4'd0 && !(aligned && adj_q[3])) begin
`ifdef TUNNEL_WRAP_EN
          x_d = (x_q == 10'd0) ? X_MAX : x_q - 10'd1;
`else
          x_d = x_q - 10'd1;
`endif
          moved = 1'b1;
        end
        default: moved = 1'b0;
      endcase
      if (moved && x_d[3:0] == 4'd0 && y_d[3:0] == 4'd0) trig_d = 1'b1;
    end

    // Step timing; evaluated after execution so a simultaneous tick counts.
    if (frame_tick) begin
      if (cnt_q == CNT_W'(STEP_PERIOD - 1)) begin
        cnt_d  = '0;
        pend_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || Restart) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      lat_q    <= '0;
      shadow_q <= 4'b1111;
      forced_q <= 1'b0;
      trig_q   <= 1'b1;
      x_q      <= 10'(START_X);
      y_q      <= 10'(START_Y);
      adj_q    <= 4'b1111;
      valid_q  <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      shadow_q <= shadow_d;
      forced_q <= forced_d;
      trig_q   <= trig_d;
      x_q      <= x_d;
      y_q      <= y_d;
      adj_q    <= adj_d;
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
    end
  end

  assign map_rd         = rd_q;
  assign map_addr       = addr_q;
  assign pacman_x       = x_q;
  assign pacman_y       = y_q;
  assign adjacent_walls = adj_q;
  assign walls_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pacman_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_mover
// Description : Self-checking bench for pacman_mover. A behavioural model
//               (position, pending step, lookup busy timer, walls taken
//               straight from the wall map) is compared against the DUT on
//               every cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_mover;
  localparam int MAP_W       = 28;
  localparam int MAP_H       = 31;
  localparam int ADDR_W      = 10;
  localparam int MAP_LAT     = 1;
  localparam int STEP_PERIOD = 1;
  localparam int START_X     = 208;
  localparam int START_Y     = 368;
  localparam int LOOKUP_CYC  = 4 * (1 + MAP_LAT) + 1;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Restart = 1'b0;
  logic              frame_tick = 1'b0;
  logic [2:0]        direction = 3'b000;
  logic              map_rd;
  logic [ADDR_W-1:0] map_addr;
  logic              map_data;
  logic [9:0]        pacman_x, pacman_y;
  logic [3:0]        adjacent_walls;
  logic              walls_valid;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  pacman_mover #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .ADDR_W(ADDR_W), .MAP_LAT(MAP_LAT),
    .STEP_PERIOD(STEP_PERIOD), .START_X(START_X), .START_Y(START_Y)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Restart(Restart), .frame_tick(frame_tick),
    .direction(direction), .map_rd(map_rd), .map_addr(map_addr),
    .map_data(map_data), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .adjacent_walls(adjacent_walls), .walls_valid(walls_valid)
  );

  // Wall map with MAP_LAT read latency; idle slots return 1 so a mistimed
  // capture shows up as a spurious wall.
  logic       wall [0:MAP_W*MAP_H-1];
  logic [MAP_LAT-1:0] pipe = '1;
  int         reads[$];
  assign map_data = pipe[MAP_LAT-1];

  always @(posedge Clk) begin
    pipe[0] <= map_rd ? wall[map_addr] : 1'b1;
    for (int i = 1; i < MAP_LAT; i++) pipe[i] <= pipe[i-1];
    if (map_rd) reads.push_back(int'(map_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         mx, my, mcnt, mbusy;
  logic [3:0] madj;
  logic       mvalid, mtrig, mpend;
  bit         mstarted = 0;

  function automatic int nb_addr(input int side, input int x, input int y);
    int r, c;
    r = y / 16;
    c = x / 16;
    case (side)
      0: r = r - 1;
      1: c = c + 1;
      2: r = r + 1;
      default: c = c - 1;
    endcase
    if (r < 0 || r >= MAP_H) return -1;
`ifdef TUNNEL_WRAP_EN
    if (c < 0) c = MAP_W - 1;
    if (c >= MAP_W) c = 0;
`else
    if (c < 0 || c >= MAP_W) return -1;
`endif
    return r * MAP_W + c;
  endfunction

  function automatic logic side_wall(input int side, input int x, input int y);
    int a;
    a = nb_addr(side, x, y);
    return (a < 0) ? 1'b1 : wall[a];
  endfunction

  initial begin
    forever begin
      bit go, moved, al;
      @(posedge Clk);
      if (Reset || Restart) begin
        mx = START_X; my = START_Y; madj = 4'hF; mvalid = 0;
        mtrig = 1; mbusy = 0; mcnt = 0; mpend = 0;
      end else begin
        go = mpend && mbusy == 0 && mvalid && !mtrig;
        if (mbusy > 0) begin
          mbusy--;
          if (mbusy == 0) begin
            for (int s = 0; s < 4; s++) madj[s] = side_wall(s, mx, my);
            mvalid = 1;
          end
        end else if (mtrig) begin
          mtrig = 0; mvalid = 0; mbusy = LOOKUP_CYC;
        end
        if (go) begin
          mpend = 0;
          moved = 0;
          al = (mx % 16 == 0) && (my % 16 == 0);
          case (direction)
            3'b100: if (mx % 16 == 0 && !(al && madj[0])) begin my--; moved = 1; end
            3'b110: if (mx % 16 == 0 && !(al && madj[2])) begin my++; moved = 1; end
            3'b101: if (my % 16 == 0 && !(al && madj[1])) begin
`ifdef TUNNEL_WRAP_EN
              mx = (mx == MAP_W*16-1) ? 0 : mx + 1;
`else
              mx = mx + 1;
`endif
              moved = 1;
            end
            3'b111: if (my % 16 == 0 && !(al && madj[3])) begin
`ifdef TUNNEL_WRAP_EN
              mx = (mx == 0) ? MAP_W*16-1 : mx - 1;
`else
              mx = mx - 1;
`endif
              moved = 1;
            end
            default: moved = 0;
          endcase
          if (moved && mx % 16 == 0 && my % 16 == 0) mtrig = 1;
        end
        if (frame_tick) begin
          mcnt++;
          if (mcnt == STEP_PERIOD) begin mcnt = 0; mpend = 1; end
        end
      end
      mstarted = 1;
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      int k, side, a;
      bit exp_rd;
      @(negedge Clk);
      if (mstarted) begin
        check("x", 32'(pacman_x), 32'(mx));
        check("y", 32'(pacman_y), 32'(my));
        check("walls_valid", 32'(walls_valid), 32'(mvalid));
        check("adjacent_walls", 32'(adjacent_walls), 32'(madj));
        exp_rd = 0;
        a = -1;
        if (mbusy > 0) begin
          k = LOOKUP_CYC - mbusy;
          side = k / (1 + MAP_LAT);
          if (k % (1 + MAP_LAT) == 0 && side < 4) begin
            a = nb_addr(side, mx, my);
            exp_rd = (a >= 0);
          end
        end
        check("map_rd", 32'(map_rd), 32'(exp_rd));
        if (exp_rd) check("map_addr", 32'(map_addr), 32'(a));
      end
    end
  end

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_spaced(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; clk1();
      frame_tick = 1'b0; clk1();
    end
  endtask

  task automatic restart_pulse();
    Restart = 1'b1; clk1();
    Restart = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < MAP_W*MAP_H; i++) wall[i] = 1'b0;

    // Reset state
    Reset = 1'b1;
    repeat (3) clk1();
    Reset = 1'b0;
    check("rst_x", 32'(pacman_x), 32'd208);
    check("rst_y", 32'(pacman_y), 32'd368);
    check("rst_adj", 32'(adjacent_walls), 32'hF);
    check("rst_valid", 32'(walls_valid), 32'd0);
    check("rst_map_rd", 32'(map_rd), 32'd0);
    check("rst_map_addr", 32'(map_addr), 32'd0);
    reads.delete();

    // First lookup: the first edge after release starts it; walls valid
    // 9 cycles later.
    for (int k = 1; k <= 10; k++) begin
      clk1();
      check("valid_timing", 32'(walls_valid), (k >= 10) ? 32'd1 : 32'd0);
    end
    check("first_adj", 32'(adjacent_walls), 32'd0);
    check("n_reads", 32'(reads.size()), 32'd4);
    if (reads.size() == 4) begin
      check("rd_up", 32'(reads[0]), 32'd629);
      check("rd_right", 32'(reads[1]), 32'd658);
      check("rd_down", 32'(reads[2]), 32'd685);
      check("rd_left", 32'(reads[3]), 32'd656);
    end

    // Move right 16 pixels along open row 23.
    direction = 3'b101;
    tick_spaced(16);
    repeat (12) clk1();
    check("right16_x", 32'(pacman_x), 32'd224);
    check("right16_y", 32'(pacman_y), 32'd368);
    check("right16_valid", 32'(walls_valid), 32'd1);
    check("right16_last_rd", (reads.size() > 0) ? 32'(reads[$]) : 32'hFFFF, 32'd657);

    // Codes 001-011 act as stop.
    direction = 3'b010;
    tick_spaced(3);
    direction = 3'b011;
    tick_spaced(2);
    check("stopcode_x", 32'(pacman_x), 32'd224);

    // Up one pixel, then right is off-axis, then down back to aligned.
    direction = 3'b100;
    tick_spaced(1);
    check("up_y", 32'(pacman_y), 32'd367);
    direction = 3'b101;
    tick_spaced(2);
    check("offaxis_x", 32'(pacman_x), 32'd224);
    direction = 3'b110;
    tick_spaced(1);
    repeat (12) clk1();
    check("down_y", 32'(pacman_y), 32'd368);

    // Wall to the right of the start tile blocks the move.
    direction = 3'b000;
    wall[658] = 1'b1;
    restart_pulse();
    repeat (12) clk1();
    check("wall_adj", 32'(adjacent_walls), 32'b0010);
    direction = 3'b101;
    tick_spaced(3);
    check("wall_x", 32'(pacman_x), 32'd208);

    // Tick during the lookup: one step right after COMMIT.
    wall[658] = 1'b0;
    restart_pulse();
    repeat (3) clk1();
    frame_tick = 1'b1; clk1();
    frame_tick = 1'b0;
    repeat (15) clk1();
    check("lookup_tick_x", 32'(pacman_x), 32'd209);
    repeat (5) clk1();
    check("lookup_tick_single", 32'(pacman_x), 32'd209);

    // Restart during the WAIT of the RIGHT read.
    direction = 3'b000;
    restart_pulse();
    repeat (4) clk1();
    Restart = 1'b1; clk1();
    Restart = 1'b0;
    check("rs_x", 32'(pacman_x), 32'd208);
    check("rs_y", 32'(pacman_y), 32'd368);
    check("rs_valid", 32'(walls_valid), 32'd0);
    check("rs_adj", 32'(adjacent_walls), 32'hF);
    check("rs_map_rd", 32'(map_rd), 32'd0);
    repeat (12) clk1();
    check("rs_relookup", 32'(walls_valid), 32'd1);

    // Run left to column 0 and probe the edge.
    direction = 3'b111;
    for (int i = 0; i < 1000; i++) begin
      frame_tick = 1'b1; clk1();
      if (pacman_x == 10'd0) break;
    end
    frame_tick = 1'b0;
    repeat (12) clk1();
    check("edge_x0", 32'(pacman_x), 32'd0);
`ifdef TUNNEL_WRAP_EN
    check("edge_left_rd", (reads.size() > 0) ? 32'(reads[$]) : 32'hFFFF, 32'(23*28+27));
    tick_spaced(1);
    check("wrap_x", 32'(pacman_x), 32'd447);
`else
    check("edge_left_wall", 32'(adjacent_walls[3]), 32'd1);
    tick_spaced(3);
    check("nowrap_x", 32'(pacman_x), 32'd0);
`endif
    repeat (3) clk1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
